// File: rtl/jk_drv_pkg.sv
// jk_drv_pkg: shared types and helpers for the JK flip-flop sequence driver.
//   drv_state_e  : driver FSM states (SYNC, RUN, HALT)
//   jk_t         : {j, k} drive pair
//   SYNC_J/SYNC_K: drive used while synchronising (forces Q=0)
//   jk_excite_f  : JK excitation table, (cur, nxt, dc) -> {j, k}
package jk_drv_pkg;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } drv_state_e;

  typedef struct packed {
    logic j;
    logic k;
  } jk_t;

  localparam logic SYNC_J = 1'b0;
  localparam logic SYNC_K = 1'b1;

  // Inputs the table leaves free take the value dc.
  function automatic jk_t jk_excite_f(input logic cur, input logic nxt, input logic dc);
    jk_t r;
    unique case ({cur, nxt})
      2'b00:   begin r.j = 1'b0; r.k = dc;   end
      2'b01:   begin r.j = 1'b1; r.k = dc;   end
      2'b10:   begin r.j = dc;   r.k = 1'b1; end
      default: begin r.j = dc;   r.k = 1'b0; end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jk_excite.sv
// jk_excite: combinational JK excitation table.
//   cur : present Q
//   nxt : desired Q after the next clock edge
//   dc  : value for don't-care inputs
//   j,k : flip-flop drive that moves Q from cur to nxt
module jk_excite
  import jk_drv_pkg::*;
(
  input  logic cur,
  input  logic nxt,
  input  logic dc,
  output logic j,
  output logic k
);

  jk_t jk;

  assign jk = jk_excite_f(cur, nxt, dc);
  assign j  = jk.j;
  assign k  = jk.k;

endmodule

// File: rtl/jk_seq_driver.sv
// jk_seq_driver: turns a valid/ready stream of target Q bits into registered
// J/K drive for a JK flip-flop, reads Q back and checks every step.
//   clk, rst_n          : clock (shared with the flip-flop), async active-low reset
//   clr                 : sync clear, back to SYNC with counters zeroed
//   tgt_valid/tgt_bit   : target stream in
//   tgt_ready           : target accepted on valid && ready
//   j, k                : registered flip-flop drive
//   q                   : flip-flop output
//   mismatch            : one-cycle pulse per failed step
//   step_cnt / err_cnt  : checked steps (wrapping) / failed steps (saturating)
//   halted              : stopped after an error (HALT_ON_ERR=1)
module jk_seq_driver
  import jk_drv_pkg::*;
#(
  parameter logic DC_FILL     = 1'b0,
  parameter bit   HALT_ON_ERR = 1'b1,
  parameter int   CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             tgt_valid,
  input  logic             tgt_bit,
  output logic             tgt_ready,
  output logic             j,
  output logic             k,
  input  logic             q,
  output logic             mismatch,
  output logic [CNT_W-1:0] step_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             halted
);

  // Stage 1 holds the expected bit while the flip-flop samples j/k,
  // stage 2 while Q settles; q is compared on the edge after stage 2 loads.
  localparam int CHK_STAGES = 2;

  drv_state_e            state;
  logic                  m;          // Q the flip-flop should hold once j/k land
  logic [CHK_STAGES:1]   vld_pipe;
  logic [CHK_STAGES:1]   exp_pipe;
  logic                  accept;
  logic                  chk;
  logic                  chk_fail;
  logic                  exc_j;
  logic                  exc_k;

  jk_excite u_excite (
    .cur (m),
    .nxt (tgt_bit),
    .dc  (DC_FILL),
    .j   (exc_j),
    .k   (exc_k)
  );

  // clr overrides a simultaneous offer.
  assign accept   = tgt_valid && tgt_ready && !clr;
  assign chk      = vld_pipe[CHK_STAGES];
  assign chk_fail = chk && (q != exp_pipe[CHK_STAGES]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_SYNC;
      j         <= SYNC_J;
      k         <= SYNC_K;
      tgt_ready <= 1'b0;
      mismatch  <= 1'b0;
      halted    <= 1'b0;
      step_cnt  <= '0;
      err_cnt   <= '0;
      m         <= 1'b0;
      vld_pipe  <= '0;
      exp_pipe  <= '0;
    end else if (clr) begin
      state     <= ST_SYNC;
      j         <= SYNC_J;
      k         <= SYNC_K;
      tgt_ready <= 1'b0;
      mismatch  <= 1'b0;
      halted    <= 1'b0;
      step_cnt  <= '0;
      err_cnt   <= '0;
      m         <= 1'b0;
      vld_pipe  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[CHK_STAGES-1:1], accept};
      exp_pipe <= {exp_pipe[CHK_STAGES-1:1], tgt_bit};

      // Checks keep running in every state so in-flight steps are counted.
      mismatch <= chk_fail;
      if (chk) step_cnt <= step_cnt + 1'b1;
      if (chk_fail && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;

      j <= 1'b0;
      k <= 1'b0;

      unique case (state)
        ST_SYNC: begin
          state     <= ST_RUN;
          m         <= 1'b0;
          tgt_ready <= 1'b1;
        end
        ST_RUN: begin
          if (HALT_ON_ERR && mismatch) begin
            // ready already dropped on the mismatch edge
            state     <= ST_HALT;
            halted    <= 1'b1;
            tgt_ready <= 1'b0;
          end else begin
            if (accept) begin
              j <= exc_j;
              k <= exc_k;
              m <= tgt_bit;
            end
            // An accept on the mismatch edge stands; none after it.
            tgt_ready <= !(HALT_ON_ERR && chk_fail);
          end
        end
        ST_HALT: begin
          tgt_ready <= 1'b0;
          halted    <= 1'b1;
        end
        default: begin
          state     <= ST_SYNC;
          j         <= SYNC_J;
          k         <= SYNC_K;
          tgt_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_seq_driver.sv
module tb_jk_seq_driver;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] rst_n, clr, tv, tbit, fen, fval;
  logic [N-1:0] rdy, jo, ko, mis, hlt, ffq, qin;
  logic [7:0]   sc0, ec0, sc1, ec1;
  logic [1:0]   sc2, ec2;

  // Three configurations: dc=0/halt, dc=1/halt, dc=0/no-halt with 2-bit counters.
  jk_seq_driver #(.DC_FILL(1'b0), .HALT_ON_ERR(1'b1), .CNT_W(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .clr(clr[0]), .tgt_valid(tv[0]), .tgt_bit(tbit[0]),
    .tgt_ready(rdy[0]), .j(jo[0]), .k(ko[0]), .q(qin[0]), .mismatch(mis[0]),
    .step_cnt(sc0), .err_cnt(ec0), .halted(hlt[0]));
  jk_seq_driver #(.DC_FILL(1'b1), .HALT_ON_ERR(1'b1), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .clr(clr[1]), .tgt_valid(tv[1]), .tgt_bit(tbit[1]),
    .tgt_ready(rdy[1]), .j(jo[1]), .k(ko[1]), .q(qin[1]), .mismatch(mis[1]),
    .step_cnt(sc1), .err_cnt(ec1), .halted(hlt[1]));
  jk_seq_driver #(.DC_FILL(1'b0), .HALT_ON_ERR(1'b0), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n[2]), .clr(clr[2]), .tgt_valid(tv[2]), .tgt_bit(tbit[2]),
    .tgt_ready(rdy[2]), .j(jo[2]), .k(ko[2]), .q(qin[2]), .mismatch(mis[2]),
    .step_cnt(sc2), .err_cnt(ec2), .halted(hlt[2]));

  // Behavioural JK flip-flops plus fault-injection mux on q.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      case ({jo[i], ko[i]})
        2'b01:   ffq[i] <= 1'b0;
        2'b10:   ffq[i] <= 1'b1;
        2'b11:   ffq[i] <= ~ffq[i];
        default: ffq[i] <= ffq[i];
      endcase
    end
  end
  assign qin = (fen & fval) | (~fen & ffq);

  // ---------------- reference model ----------------
  typedef struct {
    int due;
    bit tgt;
  } pend_t;

  int    unit, dc_p, hoe_p, w_p;
  int    cyc, checks, failures, mis_seen;
  bit    m_sync, m_ready, m_halted, m_mis, m_m;
  bit [1:0] m_jk;
  int    m_steps, m_errs;
  pend_t pend[$];

  function automatic bit [1:0] excite(input bit cur, input bit nxt, input bit dc);
    // {J,K} from the excitation table; free inputs take dc
    if (!cur && !nxt) return {1'b0, dc};
    if (!cur &&  nxt) return {1'b1, dc};
    if ( cur && !nxt) return {dc, 1'b1};
    return {dc, 1'b0};
  endfunction

  function automatic logic [7:0] get_sc();
    case (unit)
      0:       return sc0;
      1:       return sc1;
      default: return {6'd0, sc2};
    endcase
  endfunction

  function automatic logic [7:0] get_ec();
    case (unit)
      0:       return ec0;
      1:       return ec1;
      default: return {6'd0, ec2};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s unit=%0d observed=%0h expected=%0h", tag, unit, obs, exp);
    end
  endtask

  task automatic mdl_init();
    pend.delete();
    m_sync = 1; m_ready = 0; m_halted = 0; m_mis = 0; m_m = 0;
    m_jk = 2'b01; m_steps = 0; m_errs = 0;
  endtask

  task automatic check_outs();
    int mx;
    mx = (1 << w_p) - 1;
    chk("tgt_ready", rdy[unit], m_ready);
    chk("j", jo[unit], m_jk[1]);
    chk("k", ko[unit], m_jk[0]);
    chk("mismatch", mis[unit], m_mis);
    chk("halted", hlt[unit], m_halted);
    chk("step_cnt", get_sc(), m_steps & mx);
    chk("err_cnt", get_ec(), m_errs);
  endtask

  // One clock: evaluate the due check from stable inputs, take the edge,
  // advance the model and compare every output.
  task automatic tick();
    bit acc, chkv, fail, tg, prev_mis;
    int mx;
    mx = (1 << w_p) - 1;
    acc = 0; chkv = 0; fail = 0; tg = 0;
    if (rst_n[unit] && !clr[unit]) begin
      acc = tv[unit] && m_ready;
      if (pend.size() > 0 && pend[0].due == cyc + 1) begin
        chkv = 1;
        tg   = pend[0].tgt;
        void'(pend.pop_front());
        if (!fen[unit]) chk("q_follows", ffq[unit], tg);
        fail = ((fen[unit] ? fval[unit] : tg) != tg);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_n[unit] || clr[unit]) begin
      mdl_init();
    end else begin
      if (chkv) begin
        m_steps++;
        if (fail && m_errs < mx) m_errs++;
      end
      prev_mis = m_mis;
      m_mis    = fail;
      if (m_sync) begin
        m_sync = 0; m_ready = 1; m_jk = 2'b00; m_m = 0;
      end else if (m_halted) begin
        m_jk = 2'b00; m_ready = 0;
      end else if (hoe_p != 0 && prev_mis) begin
        m_halted = 1; m_ready = 0; m_jk = 2'b00;
      end else begin
        if (acc) begin
          pend_t p;
          m_jk  = excite(m_m, tbit[unit], dc_p[0]);
          m_m   = tbit[unit];
          p.due = cyc + 2;
          p.tgt = tbit[unit];
          pend.push_back(p);
        end else begin
          m_jk = 2'b00;
        end
        m_ready = !(hoe_p != 0 && fail);
      end
    end
    if (mis[unit] === 1'b1) mis_seen++;
    check_outs();
  endtask

  task automatic send(input bit b);
    tv[unit] = 1'b1; tbit[unit] = b;
    tick();
  endtask

  task automatic idle(input int n);
    tv[unit] = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst_n[unit] = 1'b0;
    mdl_init();
    #1;
    check_outs();
    tick();
    rst_n[unit] = 1'b1;
  endtask

  task automatic do_clr();
    tv[unit] = 1'b0; clr[unit] = 1'b1;
    tick();
    clr[unit] = 1'b0;
    tick();
  endtask

  task automatic setup(input int u, input int dc, input int hoe, input int w);
    unit = u; dc_p = dc; hoe_p = hoe; w_p = w;
    do_reset();
    tick();
  endtask

  task automatic rand_run(input int n);
    for (int i = 0; i < n; i++) begin
      tv[unit]   = ($urandom_range(0, 3) != 0);
      tbit[unit] = 1'($urandom_range(0, 1));
      fen[unit]  = ($urandom_range(0, 15) == 0);
      fval[unit] = 1'($urandom_range(0, 1));
      clr[unit]  = ((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 49) == 0);
      tick();
    end
    tv[unit] = 0; fen[unit] = 0; clr[unit] = 0;
    idle(3);
  endtask

  bit       tgt_seq [5];
  bit [1:0] jk_dc0  [5];
  bit [1:0] jk_dc1  [5];

  initial begin
    rst_n = '0; clr = '0; tv = '0; tbit = '0; fen = '0; fval = '0;
    checks = 0; failures = 0; cyc = 0; mis_seen = 0;
    tgt_seq = '{1, 1, 0, 0, 1};
    jk_dc0  = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    jk_dc1  = '{2'b11, 2'b10, 2'b11, 2'b01, 2'b11};
    repeat (2) @(posedge clk);
    #1;

    // ---- DC_FILL=0, HALT_ON_ERR=1 ----
    setup(0, 0, 1, 8);
    chk("ready_after_sync", rdy[unit], 1);
    mis_seen = 0;
    for (int i = 0; i < 5; i++) begin
      send(tgt_seq[i]);
      chk("jk_seq_dc0", {jo[unit], ko[unit]}, jk_dc0[i]);
    end
    idle(3);
    chk("steps_5", get_sc(), 5);
    chk("errs_0", get_ec(), 0);
    chk("no_mismatch", mis_seen, 0);

    // valid gaps 1,0,0,1
    send(0);
    idle(1);
    chk("gap_jk", {jo[unit], ko[unit]}, 0);
    chk("gap_q_hold", ffq[unit], 0);
    idle(1);
    chk("gap_q_hold2", ffq[unit], 0);
    send(1);
    idle(3);
    chk("gap_steps", get_sc(), 7);

    // q forced low for the second step
    do_clr();
    send(1);
    send(1);
    send(0);
    fen[unit] = 1; fval[unit] = 0;
    send(1);
    fen[unit] = 0;
    chk("mis_pulse", mis[unit], 1);
    tv[unit] = 1; tbit[unit] = 0;
    tick();
    chk("halt_rise", hlt[unit], 1);
    chk("halt_ready", rdy[unit], 0);
    idle(3);
    chk("halt_steps", get_sc(), 4);
    chk("halt_errs", get_ec(), 1);
    chk("halt_stays", hlt[unit], 1);

    // reset one cycle after an accept
    do_clr();
    send(1);
    idle(1);
    mis_seen = 0;
    do_reset();
    chk("rst_jk", {jo[unit], ko[unit]}, 2'b01);
    tick();
    chk("rel_jk", {jo[unit], ko[unit]}, 2'b00);
    chk("rel_ready", rdy[unit], 1);
    idle(3);
    chk("rst_no_pulse", mis_seen, 0);
    rand_run(300);
    rst_n[unit] = 0;

    // ---- DC_FILL=1, HALT_ON_ERR=1 ----
    setup(1, 1, 1, 8);
    for (int i = 0; i < 5; i++) begin
      send(tgt_seq[i]);
      chk("jk_seq_dc1", {jo[unit], ko[unit]}, jk_dc1[i]);
    end
    idle(3);
    chk("dc1_steps", get_sc(), 5);
    chk("dc1_errs", get_ec(), 0);
    rand_run(300);
    rst_n[unit] = 0;

    // ---- HALT_ON_ERR=0, CNT_W=2, q stuck at 1 ----
    setup(2, 0, 0, 2);
    fen[unit] = 1; fval[unit] = 1;
    mis_seen = 0;
    repeat (3) send(0);
    idle(3);
    chk("stuck_errs", get_ec(), 3);
    chk("stuck_pulses", mis_seen, 3);
    repeat (2) send(0);
    idle(3);
    chk("sat_errs", get_ec(), 3);
    chk("wrap_steps", get_sc(), 1);
    chk("no_halt", hlt[unit], 0);
    fen[unit] = 0;
    rand_run(300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
